// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice through sum(A[i]*B[i]) over a valid/ready operand stream,
// drains the slice pipeline and returns the accumulated 48-bit P value as RESULT.
`timescale 1ns/1ps
module dsp_mac_sequencer #(
    parameter int          LAT    = 3,
    parameter int          LEN_W  = 8,
    parameter logic [7:0]  MAC_OP = 8'h09
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               START,
    input  logic [LEN_W-1:0]   LEN,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [17:0]        A_IN,
    input  logic [17:0]        B_IN,
    output logic [17:0]        DSP_A,
    output logic [17:0]        DSP_B,
    output logic               CEA,
    output logic               CEB,
    output logic               CEM,
    output logic               CEP,
    output logic               RSTA,
    output logic               RSTB,
    output logic               RSTM,
    output logic               RSTP,
    output logic [7:0]         OPMODE,
    input  logic [47:0]        P_IN,
    output logic [47:0]        RESULT,
    output logic               RESULT_VALID,
    output logic               BUSY
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Last drain index; a single-stage slice skips DRAIN entirely.
    localparam int   DRAIN_LAST   = (LAT > 1) ? (LAT - 2) : 0;
    localparam logic SKIP_DRAIN   = (LAT == 1);

    state_t             state_reg, state_next;
    logic [LEN_W-1:0]   count_reg, count_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic [2:0]         drain_reg, drain_next;
    logic [47:0]        result_reg, result_next;
    logic               result_valid_reg, result_valid_next;
    logic [LEN_W-1:0]   count_inc;

    assign count_inc    = count_reg + {{(LEN_W-1){1'b0}}, 1'b1};
    assign RESULT       = result_reg;
    assign RESULT_VALID = result_valid_reg;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_reg        <= S_IDLE;
            count_reg        <= '0;
            len_reg          <= '0;
            drain_reg        <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            count_reg        <= count_next;
            len_reg          <= len_next;
            drain_reg        <= drain_next;
            result_reg       <= result_next;
            result_valid_reg <= result_valid_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        count_next        = count_reg;
        len_next          = len_reg;
        drain_next        = drain_reg;
        result_next       = result_reg;
        result_valid_next = 1'b0;
        IN_READY          = 1'b0;
        DSP_A             = '0;
        DSP_B             = '0;
        CEA               = 1'b0;
        CEB               = 1'b0;
        CEM               = 1'b0;
        CEP               = 1'b0;
        RSTA              = 1'b0;
        RSTB              = 1'b0;
        RSTM              = 1'b0;
        RSTP              = 1'b0;
        OPMODE            = 8'h00;
        BUSY              = 1'b1;

        case (state_reg)
            S_IDLE: begin
                BUSY = 1'b0;
                if (START) begin
                    len_next   = LEN;
                    count_next = '0;
                    state_next = (LEN == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                RSTA       = 1'b1;
                RSTB       = 1'b1;
                RSTM       = 1'b1;
                RSTP       = 1'b1;
                state_next = S_FEED;
            end
            S_FEED: begin
                IN_READY = 1'b1;
                OPMODE   = MAC_OP;
                // Stalls freeze every stage so bubbles never reach the accumulator.
                if (IN_VALID) begin
                    DSP_A      = A_IN;
                    DSP_B      = B_IN;
                    CEA        = 1'b1;
                    CEB        = 1'b1;
                    CEM        = 1'b1;
                    CEP        = 1'b1;
                    count_next = count_inc;
                    drain_next = '0;
                    if (count_inc == len_reg)
                        state_next = SKIP_DRAIN ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                OPMODE = MAC_OP;
                CEA    = 1'b1;
                CEB    = 1'b1;
                CEM    = 1'b1;
                CEP    = 1'b1;
                if (drain_reg == 3'(DRAIN_LAST))
                    state_next = S_DONE;
                else
                    drain_next = drain_reg + 3'd1;
            end
            S_DONE: begin
                OPMODE            = MAC_OP;
                result_next       = (len_reg == '0) ? 48'd0 : P_IN;
                result_valid_next = 1'b1;
                state_next        = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP48A1 slices (LAT=3 and LAT=1 builds),
// expected sums queued at stimulus time and compared when RESULT_VALID strobes.
`timescale 1ns/1ps
module tb_dsp_mac_sequencer;

    localparam logic [7:0] MAC_OP = 8'h09;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- LAT=3 instance ----------------
    logic               rstn, start, in_valid, in_ready;
    logic [7:0]         len, opmode;
    logic [17:0]        a_in, b_in;
    logic signed [17:0] dsp_a, dsp_b;
    logic               cea, ceb, cem, cep, rsta, rstb, rstm, rstp;
    logic [47:0]        result;
    logic               result_valid, busy;
    logic signed [17:0] a_r, b_r;
    logic signed [47:0] m_r, p_r;

    dsp_mac_sequencer #(.LAT(3), .LEN_W(8), .MAC_OP(MAC_OP)) u_dut (
        .CLK(clk), .RSTN(rstn), .START(start), .LEN(len),
        .IN_VALID(in_valid), .IN_READY(in_ready), .A_IN(a_in), .B_IN(b_in),
        .DSP_A(dsp_a), .DSP_B(dsp_b),
        .CEA(cea), .CEB(ceb), .CEM(cem), .CEP(cep),
        .RSTA(rsta), .RSTB(rstb), .RSTM(rstm), .RSTP(rstp),
        .OPMODE(opmode), .P_IN(p_r), .RESULT(result),
        .RESULT_VALID(result_valid), .BUSY(busy)
    );

    // Slice model: A/B reg -> M reg -> P accumulator.
    always_ff @(posedge clk) begin
        if (rsta) a_r <= '0; else if (cea) a_r <= dsp_a;
        if (rstb) b_r <= '0; else if (ceb) b_r <= dsp_b;
        if (rstm) m_r <= '0; else if (cem) m_r <= 48'(a_r) * 48'(b_r);
        if (rstp) p_r <= '0;
        else if (cep) p_r <= (opmode == 8'h09) ? (p_r + m_r) : m_r;
    end

    // ---------------- LAT=1 instance ----------------
    logic               rstn1, start1, in_valid1, in_ready1;
    logic [7:0]         len1, opmode1;
    logic [17:0]        a_in1, b_in1;
    logic signed [17:0] dsp_a1, dsp_b1;
    logic               cea1, ceb1, cem1, cep1, rsta1, rstb1, rstm1, rstp1;
    logic [47:0]        result1;
    logic               result_valid1, busy1;
    logic signed [47:0] p1_r;

    dsp_mac_sequencer #(.LAT(1), .LEN_W(8), .MAC_OP(MAC_OP)) u_dut1 (
        .CLK(clk), .RSTN(rstn1), .START(start1), .LEN(len1),
        .IN_VALID(in_valid1), .IN_READY(in_ready1), .A_IN(a_in1), .B_IN(b_in1),
        .DSP_A(dsp_a1), .DSP_B(dsp_b1),
        .CEA(cea1), .CEB(ceb1), .CEM(cem1), .CEP(cep1),
        .RSTA(rsta1), .RSTB(rstb1), .RSTM(rstm1), .RSTP(rstp1),
        .OPMODE(opmode1), .P_IN(p1_r), .RESULT(result1),
        .RESULT_VALID(result_valid1), .BUSY(busy1)
    );

    always_ff @(posedge clk) begin
        if (rstp1) p1_r <= '0;
        else if (cep1) p1_r <= (opmode1 == 8'h09) ? (p1_r + 48'(dsp_a1) * 48'(dsp_b1))
                                                  : 48'(dsp_a1) * 48'(dsp_b1);
    end

    // ---------------- activity monitor ----------------
    int cyc = 0, ce_cnt = 0, ce_low_cnt = 0, rst_cnt = 0, busy_cnt = 0, strobe_cnt = 0;
    int busy1_cnt = 0, strobe1_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cea)            ce_cnt      <= ce_cnt + 1;
        if (busy && !cea)   ce_low_cnt  <= ce_low_cnt + 1;
        if (rsta)           rst_cnt     <= rst_cnt + 1;
        if (busy)           busy_cnt    <= busy_cnt + 1;
        if (result_valid)   strobe_cnt  <= strobe_cnt + 1;
        if (busy1)          busy1_cnt   <= busy1_cnt + 1;
        if (result_valid1)  strobe1_cnt <= strobe1_cnt + 1;
    end

    // ---------------- scoreboard & stimulus ----------------
    logic [47:0] q0[$];
    logic [47:0] q1[$];
    int pa[$];
    int pb[$];

    task automatic run_job(input string tag, input int n, input int gap, input bit poke,
                           output int lat);
        longint sum = 0;
        int     st, guard;
        logic [47:0] held;
        for (int i = 0; i < n; i++) sum += longint'(pa[i]) * longint'(pb[i]);
        q0.push_back(48'(sum));
        len   = 8'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        st    = cyc;
        for (int i = 0; i < n; i++) begin
            a_in     = 18'(pa[i]);
            b_in     = 18'(pb[i]);
            in_valid = 1'b1;
            if (poke && i == 0) begin
                start = 1'b1;
                len   = 8'd7;
            end
            guard = 0;
            @(negedge clk);
            while (!in_ready && guard < 50) begin
                guard++;
                @(negedge clk);
            end
            check_val({tag, "_ready"}, 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            start    = 1'b0;
            if (gap > 0 && i < n - 1) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
        end
        guard = 0;
        @(negedge clk);
        while (!result_valid && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        lat = cyc - st + 1;
        check_val({tag, "_strobe"}, 64'(result_valid), 64'd1);
        if (q0.size() == 0) check_val({tag, "_sb_empty"}, 64'd0, 64'd1);
        else                check_val({tag, "_result"}, 64'(result), 64'(q0.pop_front()));
        held = result;
        @(negedge clk);
        check_val({tag, "_strobe_1cyc"}, 64'(result_valid), 64'd0);
        check_val({tag, "_hold"}, 64'(result), 64'(held));
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    int lat, s_str, s_ce, s_cel, s_rst, s_busy, guard1, st1;

    task automatic snap();
        s_str  = strobe_cnt;
        s_ce   = ce_cnt;
        s_cel  = ce_low_cnt;
        s_rst  = rst_cnt;
        s_busy = busy_cnt;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; a_in = '0; b_in = '0;
        rstn1 = 1'b0; start1 = 1'b0; len1 = '0; in_valid1 = 1'b0; a_in1 = '0; b_in1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ctrl", 64'({in_ready, cea, ceb, cem, cep, rsta, rstb, rstm, rstp, busy, result_valid}), 64'd0);
        check_val("rst_result", 64'(result), 64'd0);
        check_val("rst_opmode", 64'(opmode), 64'd0);
        check_val("rst_dsp_ab", 64'({dsp_a, dsp_b}), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1; rstn1 = 1'b1;
        @(posedge clk); #1;

        // Basic job, no stalls.
        pa = '{2, 4, -1}; pb = '{3, 5, 7};
        snap();
        run_job("basic", 3, 0, 1'b0, lat);
        check_val("basic_latency", 64'(lat), 64'd8);
        check_val("basic_ce_cycles", 64'(ce_cnt - s_ce), 64'd5);
        check_val("basic_ce_low", 64'(ce_low_cnt - s_cel), 64'd2);
        check_val("basic_rst_cycles", 64'(rst_cnt - s_rst), 64'd1);
        check_val("basic_strobes", 64'(strobe_cnt - s_str), 64'd1);

        // Same job with one idle cycle between each pair.
        snap();
        run_job("stall", 3, 1, 1'b0, lat);
        check_val("stall_latency", 64'(lat), 64'd10);
        check_val("stall_ce_cycles", 64'(ce_cnt - s_ce), 64'd5);
        check_val("stall_ce_low", 64'(ce_low_cnt - s_cel), 64'd4);
        check_val("stall_strobes", 64'(strobe_cnt - s_str), 64'd1);

        // Empty job.
        pa = {}; pb = {};
        snap();
        run_job("len0", 0, 0, 1'b0, lat);
        check_val("len0_latency", 64'(lat), 64'd2);
        check_val("len0_ce_cycles", 64'(ce_cnt - s_ce), 64'd0);
        check_val("len0_rst_cycles", 64'(rst_cnt - s_rst), 64'd0);
        check_val("len0_busy", 64'(busy_cnt - s_busy), 64'd1);

        // START pulsed while busy must be ignored; next job starts from a clean P.
        pa = '{3, 1}; pb = '{3, 2};
        snap();
        run_job("poke", 2, 0, 1'b1, lat);
        check_val("poke_strobes", 64'(strobe_cnt - s_str), 64'd1);
        pa = '{6}; pb = '{7};
        run_job("b2b", 1, 0, 1'b0, lat);
        check_val("b2b_latency", 64'(lat), 64'd6);

        // Reset mid-FEED aborts without a strobe.
        snap();
        len = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; a_in = 18'd9; b_in = 18'd9;
        repeat (3) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check_val("abort_busy", 64'({busy, in_ready}), 64'd0);
        check_val("abort_result_cleared", 64'(result), 64'd0);
        repeat (10) @(negedge clk);
        check_val("abort_no_strobe", 64'(strobe_cnt - s_str), 64'd0);
        @(posedge clk); #1;
        pa = '{-131072}; pb = '{-131072};
        run_job("after_abort", 1, 0, 1'b0, lat);
        check_val("after_abort_latency", 64'(lat), 64'd6);

        // LAT=1 build: no drain cycles.
        q1.push_back(48'(5 * 5 + 1 * 1));
        s_busy = busy1_cnt;
        s_str  = strobe1_cnt;
        len1 = 8'd2; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; st1 = cyc;
        in_valid1 = 1'b1; a_in1 = 18'd5; b_in1 = 18'd5;
        guard1 = 0;
        @(negedge clk);
        while (!in_ready1 && guard1 < 50) begin
            guard1++;
            @(negedge clk);
        end
        check_val("lat1_ready", 64'(in_ready1), 64'd1);
        @(posedge clk); #1;
        a_in1 = 18'd1; b_in1 = 18'd1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        guard1 = 0;
        @(negedge clk);
        while (!result_valid1 && guard1 < 100) begin
            guard1++;
            @(negedge clk);
        end
        check_val("lat1_strobe", 64'(result_valid1), 64'd1);
        check_val("lat1_latency", 64'(cyc - st1 + 1), 64'd5);
        if (q1.size() == 0) check_val("lat1_sb_empty", 64'd0, 64'd1);
        else                check_val("lat1_result", 64'(result1), 64'(q1.pop_front()));
        repeat (3) @(negedge clk);
        check_val("lat1_busy", 64'(busy1_cnt - s_busy), 64'd4);
        check_val("lat1_strobes", 64'(strobe1_cnt - s_str), 64'd1);

        check_val("sb_drained", 64'(q0.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
